// File: rtl/bus_pkg.sv
// Shared types and address-map constants for the system bus arbiter and its address decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    TGT_MEM  = 2'd0,
    TGT_GPIO = 2'd1,
    TGT_ERR  = 2'd2
  } bus_tgt_e;

  // Upper address bits identifying the 8KB memory and the 4KB GPIO page.
  localparam logic [18:0] MEM_BASE_HI = 19'h0;
  localparam logic [19:0] GPIO_PAGE   = 20'hFFFF2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_cmd_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: maps a byte address to memory, GPIO or the error target.
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [31:0] addr_i,
  output bus_tgt_e    tgt_o
);

  // Low page-offset bits never affect the target.
  logic unused_offset;
  assign unused_offset = ^addr_i[11:0];

  always_comb begin
    tgt_o = TGT_ERR;
    if (addr_i[31:13] == MEM_BASE_HI) begin
      tgt_o = TGT_MEM;
    end else if (addr_i[31:12] == GPIO_PAGE) begin
      tgt_o = TGT_GPIO;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and three-phase (grant/access/response) bus sequencer.
module bus_arbiter
  import bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        cs_mem,
  output logic        cs_gpio,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_be,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] gpio_rdata
);

  bus_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       owner_q, owner_d;
  bus_cmd_t   cmd_q, cmd_d;
  bus_tgt_e   tgt;

  logic        in_access;
  logic        in_resp;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  bus_addr_decode u_decode (
    .addr_i (cmd_q.addr),
    .tgt_o  (tgt)
  );

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // On a tie the master that did not win last time takes the bus.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if ((state_q == IDLE) && !reset) begin
      if (m0_req && m1_req) begin
        if (last_grant_q) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cmd_d        = cmd_q;
    unique case (state_q)
      IDLE: begin
        if (m0_gnt) begin
          state_d      = ACCESS;
          last_grant_d = 1'b0;
          owner_d      = 1'b0;
          cmd_d        = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
        end else if (m1_gnt) begin
          state_d      = ACCESS;
          last_grant_d = 1'b1;
          owner_d      = 1'b1;
          cmd_d        = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cmd_q        <= cmd_d;
    end
  end

  // Slave command is only driven while a mapped target is selected.
  always_comb begin
    cs_mem  = in_access && (tgt == TGT_MEM);
    cs_gpio = in_access && (tgt == TGT_GPIO);
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_be    = '0;
    if (cs_mem || cs_gpio) begin
      s_we    = cmd_q.we;
      s_addr  = cmd_q.addr;
      s_wdata = cmd_q.wdata;
      s_be    = cmd_q.be;
    end
  end

  always_comb begin
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    unique case (tgt)
      TGT_MEM:  rsp_rdata = cmd_q.we ? 32'h0 : mem_rdata;
      TGT_GPIO: rsp_rdata = cmd_q.we ? 32'h0 : gpio_rdata;
      default:  rsp_err   = 1'b1;
    endcase
  end

  always_comb begin
    m0_rvalid = in_resp && !owner_q;
    m1_rvalid = in_resp && owner_q;
    m0_rdata  = m0_rvalid ? rsp_rdata : 32'h0;
    m1_rdata  = m1_rvalid ? rsp_rdata : 32'h0;
    m0_err    = m0_rvalid && rsp_err;
    m1_err    = m1_rvalid && rsp_err;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a byte-enable memory model and a fixed-value GPIO slave.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        cs_mem, cs_gpio, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [31:0] mem_rdata, gpio_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:2047];

  bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_be      (m0_be),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_be      (m1_be),
    .m0_gnt     (m0_gnt),
    .m1_gnt     (m1_gnt),
    .m0_rvalid  (m0_rvalid),
    .m1_rvalid  (m1_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_rdata   (m1_rdata),
    .m0_err     (m0_err),
    .m1_err     (m1_err),
    .cs_mem     (cs_mem),
    .cs_gpio    (cs_gpio),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_be       (s_be),
    .mem_rdata  (mem_rdata),
    .gpio_rdata (gpio_rdata)
  );

  always #5 clk = ~clk;

  // Slaves: writes land on the ACCESS edge, read data is valid the following cycle.
  always @(posedge clk) begin
    if (cs_mem && s_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_be[b]) mem[s_addr[12:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
    mem_rdata  <= (cs_mem && !s_we) ? mem[s_addr[12:2]] : 32'h0;
    gpio_rdata <= (cs_gpio && !s_we) ? ((s_addr == 32'hFFFF_2004) ? 32'hA5 : 32'h5A) : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ":ctl"}, {23'b0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
                          cs_mem, cs_gpio, s_we}, 32'h0);
    check({tag, ":bus"}, s_addr | s_wdata | {28'b0, s_be}, 32'h0);
    check({tag, ":rdata"}, m0_rdata | m1_rdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("reset");
  endtask

  // One complete transaction: grant (T), access (T+1), response (T+2).
  task automatic xact(input string tag, input int m, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input logic [1:0] exp_cs,
                      input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] oh;
    oh = (m == 0) ? 32'd1 : 32'd2;
    @(negedge clk);
    drive(m, 1'b1, we, addr, wdata, be);
    #1;
    check({tag, ":gnt"}, {30'b0, m1_gnt, m0_gnt}, oh);
    check({tag, ":cs_T"}, {30'b0, cs_gpio, cs_mem}, 32'h0);
    @(negedge clk);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check({tag, ":cs"}, {30'b0, cs_gpio, cs_mem}, {30'b0, exp_cs});
    check({tag, ":rvalid_T1"}, {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
    if (exp_cs != 2'b00) begin
      check({tag, ":s_addr"}, s_addr, addr);
      check({tag, ":s_we"}, {31'b0, s_we}, {31'b0, we});
      if (we) begin
        check({tag, ":s_wdata"}, s_wdata, wdata);
        check({tag, ":s_be"}, {28'b0, s_be}, {28'b0, be});
      end
    end
    @(negedge clk);
    #1;
    check({tag, ":rvalid"}, {30'b0, m1_rvalid, m0_rvalid}, oh);
    check({tag, ":rdata"}, (m == 0) ? m0_rdata : m1_rdata, exp_rdata);
    check({tag, ":other_rdata"}, (m == 0) ? m1_rdata : m0_rdata, 32'h0);
    check({tag, ":err"}, {30'b0, m1_err, m0_err}, exp_err ? oh : 32'h0);
    check({tag, ":cs_T2"}, {30'b0, cs_gpio, cs_mem}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_reset();

    xact("m0_wr",   0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b01, 32'h0, 1'b0);
    xact("m0_rd",   0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b01, 32'hDEAD_BEEF, 1'b0);
    xact("m1_gpio", 1, 1'b0, 32'hFFFF_2004, 32'h0,         4'h0, 2'b10, 32'h0000_00A5, 1'b0);
    xact("err_lo",  0, 1'b0, 32'h0000_2000, 32'h0,         4'h0, 2'b00, 32'h0, 1'b1);
    xact("err_hi",  0, 1'b0, 32'hFFFF_1000, 32'h0,         4'h0, 2'b00, 32'h0, 1'b1);
    xact("m1_pwr",  1, 1'b1, 32'h0000_0010, 32'h0000_1234, 4'h3, 2'b01, 32'h0, 1'b0);
    xact("m0_prd",  0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b01, 32'hDEAD_1234, 1'b0);

    // Both masters requesting continuously from reset.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t == 0) begin
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 32'hFFFF_2004, 32'h0, 4'h0);
      end
      #1;
      check($sformatf("rr%0d:gnt", t), {30'b0, m1_gnt, m0_gnt}, (t % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      #1;
      check($sformatf("rr%0d:gnt_busy", t), {30'b0, m1_gnt, m0_gnt}, 32'h0);
      check($sformatf("rr%0d:cs", t), {30'b0, cs_gpio, cs_mem}, (t % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      #1;
      check($sformatf("rr%0d:rvalid", t), {30'b0, m1_rvalid, m0_rvalid},
            (t % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr%0d:rdata", t), m0_rdata | m1_rdata,
            (t % 2 == 0) ? 32'hDEAD_1234 : 32'h0000_00A5);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset during ACCESS of an M1 read drops the transaction.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'hFFFF_2004, 32'h0, 4'h0);
    #1;
    check("rst_acc:gnt", {31'b0, m1_gnt}, 32'h1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    #1;
    check("rst_acc:cs", {30'b0, cs_gpio, cs_mem}, 32'd2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("rst_acc:after");
    xact("rst_retry", 1, 1'b0, 32'hFFFF_2004, 32'h0, 4'h0, 2'b10, 32'h0000_00A5, 1'b0);

    // M1 alone, back-to-back reads.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      #1;
      check($sformatf("b2b%0d:gnt", c), {31'b0, m1_gnt}, (c % 3 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b%0d:rvalid", c), {31'b0, m1_rvalid}, (c % 3 == 2) ? 32'd1 : 32'd0);
      check($sformatf("b2b%0d:rdata", c), m1_rdata, (c % 3 == 2) ? 32'hDEAD_1234 : 32'h0);
    end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
